// File: rtl/spi_reg_writer.sv
// SPI register writer: queues {addr,data} commands in a 4-entry FIFO and
// shifts each out as a 16-bit MSB-first frame framed by spi_enable.
module spi_reg_writer #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] fifo_level,
    output logic       spi_clk,
    output logic       spi_enable,
    output logic       spi_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    // Counter widths floor at 1 bit so CLK_DIV=1 / GAP_CYCLES=1 stay legal.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [15:0]   fifo_mem [0:3];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;

    logic [1:0]    state;
    logic [DW-1:0] div_cnt;
    logic [GW-1:0] gap_cnt;
    logic [3:0]    bit_cnt;
    logic [15:0]   shreg;
    logic          clk_q;
    logic          done_q;

    logic          push;
    logic          pop;
    logic          div_end;
    logic          gap_end;

    always_comb begin
        push    = cmd_valid && (count != 3'd4);
        div_end = (div_cnt == DIV_LAST);
        gap_end = (gap_cnt == GAP_LAST);
        pop     = (count != 3'd0) && ((state == IDLE) || ((state == GAP) && gap_end));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {cmd_addr, cmd_data};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            clk_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= fifo_mem[rd_ptr];
                        div_cnt <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        clk_q   <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt <= '0;
                        if (clk_q) begin
                            // Data advances on the falling edge so it is settled before the next rise.
                            clk_q <= 1'b0;
                            shreg <= {shreg[14:0], 1'b0};
                        end else if (bit_cnt == 4'd15) begin
                            gap_cnt <= '0;
                            done_q  <= 1'b1;
                            state   <= GAP;
                        end else begin
                            clk_q   <= 1'b1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (pop) begin
                            shreg   <= fifo_mem[rd_ptr];
                            div_cnt <= '0;
                            state   <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready  = (count != 3'd4);
        fifo_level = count;
        busy       = (state != IDLE) || (count != 3'd0);
        frame_done = done_q;
        spi_enable = (state == SETUP) || (state == SHIFT);
        spi_clk    = clk_q;
        spi_data   = spi_enable && shreg[15];
    end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: default-parameter instance plus a
// CLK_DIV=1/GAP_CYCLES=1 instance, with bus monitors decoding frames.
module tb_spi_reg_writer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, busy, frame_done, spi_clk, spi_enable, spi_data;
    logic [2:0] fifo_level;

    logic       f_rst = 1'b1;
    logic       f_valid = 1'b0;
    logic [7:0] f_addr = '0;
    logic [7:0] f_data = '0;
    logic       f_ready, f_busy, f_done, f_sclk, f_en, f_sdata;
    logic [2:0] f_level;

    spi_reg_writer #(.CLK_DIV(4), .GAP_CYCLES(16)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy),
        .frame_done(frame_done), .fifo_level(fifo_level), .spi_clk(spi_clk),
        .spi_enable(spi_enable), .spi_data(spi_data)
    );

    spi_reg_writer #(.CLK_DIV(1), .GAP_CYCLES(1)) u_fast (
        .clk(clk), .rst(f_rst), .cmd_valid(f_valid), .cmd_ready(f_ready),
        .cmd_addr(f_addr), .cmd_data(f_data), .busy(f_busy),
        .frame_done(f_done), .fifo_level(f_level), .spi_clk(f_sclk),
        .spi_enable(f_en), .spi_data(f_sdata)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor state for the default instance
    logic [15:0] frames[$];
    int          starts[$];
    int          rise_cnt = 0, done_cnt = 0, en_err = 0, stab_err = 0, ready_err = 0;
    int          saw_full = 0;

    initial begin
        logic p_clk, p_en, p_data;
        logic [15:0] sh;
        int nbits;
        p_clk = 0; p_en = 0; p_data = 0; sh = '0; nbits = 0;
        forever begin
            @(negedge clk);
            if (spi_enable && !p_en) begin
                starts.push_back(cyc);
                nbits = 0;
                if (spi_clk) en_err++;
            end
            if (spi_clk && !p_clk) begin
                rise_cnt++;
                if (!spi_enable) en_err++;
                if (spi_data !== p_data) stab_err++;
                sh = {sh[14:0], spi_data};
                nbits++;
                if (nbits == 16) frames.push_back(sh);
            end
            if ((spi_clk != p_clk) && !spi_enable && !p_en) en_err++;
            if (frame_done) done_cnt++;
            if (fifo_level == 3'd4) begin
                saw_full = 1;
                if (cmd_ready) ready_err++;
            end
            p_clk = spi_clk; p_en = spi_enable; p_data = spi_data;
        end
    end

    // Monitor state for the fast instance
    logic [15:0] f_frames[$];
    int          f_starts[$];
    int          f_rises = 0, f_dones = 0, f_per_err = 0, f_stab_err = 0;

    initial begin
        logic p_clk, p_en, p_data;
        logic [15:0] sh;
        int nbits, last_rise;
        p_clk = 0; p_en = 0; p_data = 0; sh = '0; nbits = 0; last_rise = 0;
        forever begin
            @(negedge clk);
            if (f_en && !p_en) begin
                f_starts.push_back(cyc);
                nbits = 0;
            end
            if (f_sclk && !p_clk) begin
                f_rises++;
                if (nbits > 0 && (cyc - last_rise) != 2) f_per_err++;
                if (f_sdata !== p_data || !f_en) f_stab_err++;
                last_rise = cyc;
                sh = {sh[14:0], f_sdata};
                nbits++;
                if (nbits == 16) f_frames.push_back(sh);
            end
            if (f_done) f_dones++;
            p_clk = f_sclk; p_en = f_en; p_data = f_sdata;
        end
    end

    // Offers one command with cmd_valid left high; returns after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] d);
        int t;
        cmd_addr = a;
        cmd_data = d;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 1000) begin
            tick();
            t++;
        end
        check("send_ready", cmd_ready, 1'b1);
        tick();
    endtask

    task automatic clear_mon();
        frames.delete();
        starts.delete();
        rise_cnt = 0; done_cnt = 0; en_err = 0; stab_err = 0; ready_err = 0; saw_full = 0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int t;
        t = 0;
        while (busy && t < bound) begin
            tick();
            t++;
        end
        check(tag, busy, 1'b0);
    endtask

    logic [15:0] t3_cmds [6] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F1E, 16'hC381};

    initial begin
        int t, nb;
        // Reset
        rst = 1'b1; f_rst = 1'b1;
        repeat (2) tick();
        check("rst_enable", spi_enable, 1'b0);
        check("rst_sclk", spi_clk, 1'b0);
        check("rst_sdata", spi_data, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_level", fifo_level, 3'd0);
        rst = 1'b0; f_rst = 1'b0;
        repeat (2) tick();

        // Single write 0x01/0xA5
        clear_mon();
        send(8'h01, 8'hA5);
        cmd_valid = 1'b0;
        t = 0;
        while (!frame_done && t < 400) begin tick(); t++; end
        check("single_done_seen", frame_done, 1'b1);
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy && !spi_enable && !spi_clk) nb++;
            tick();
        end
        check("single_gap_len", nb, 16);
        check("single_busy_drop", busy, 1'b0);
        check("single_frames", frames.size(), 1);
        if (frames.size() > 0) check("single_word", frames[0], 16'h01A5);
        check("single_rises", rise_cnt, 16);
        check("single_done_cnt", done_cnt, 1);
        check("single_en_err", en_err, 0);
        check("single_stab_err", stab_err, 0);

        // Six commands, cmd_valid held high
        clear_mon();
        for (int i = 0; i < 6; i++) send(t3_cmds[i][15:8], t3_cmds[i][7:0]);
        cmd_valid = 1'b0;
        t = 0;
        while (frames.size() < 6 && t < 2000) begin tick(); t++; end
        wait_idle("burst_idle", 200);
        check("burst_frames", frames.size(), 6);
        for (int i = 0; i < 6 && i < frames.size(); i++)
            check($sformatf("burst_word%0d", i), frames[i], t3_cmds[i]);
        check("burst_starts", starts.size(), 6);
        for (int i = 1; i < 6 && i < starts.size(); i++)
            check($sformatf("burst_spacing%0d", i), starts[i] - starts[i-1], 148);
        check("burst_saw_full", saw_full, 1);
        check("burst_ready_at_full", ready_err, 0);
        check("burst_done_cnt", done_cnt, 6);
        check("burst_rises", rise_cnt, 96);
        check("burst_en_err", en_err, 0);
        check("burst_stab_err", stab_err, 0);

        // Push and pop in the same cycle at level 2
        clear_mon();
        send(8'hA1, 8'h11);
        send(8'hB2, 8'h22);
        send(8'hC3, 8'h33);
        cmd_valid = 1'b0;
        t = 0;
        while (!frame_done && t < 400) begin tick(); t++; end
        check("pp_done_seen", frame_done, 1'b1);
        repeat (15) tick();
        check("pp_level_before", fifo_level, 3'd2);
        check("pp_enable_before", spi_enable, 1'b0);
        cmd_addr = 8'hD4; cmd_data = 8'h44; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("pp_level_after", fifo_level, 3'd2);
        check("pp_enable_after", spi_enable, 1'b1);
        t = 0;
        while (frames.size() < 4 && t < 1000) begin tick(); t++; end
        wait_idle("pp_idle", 200);
        check("pp_frames", frames.size(), 4);
        if (frames.size() == 4) begin
            check("pp_word0", frames[0], 16'hA111);
            check("pp_word1", frames[1], 16'hB222);
            check("pp_word2", frames[2], 16'hC333);
            check("pp_word3", frames[3], 16'hD444);
        end

        // Reset mid-frame with two commands queued
        clear_mon();
        send(8'h5A, 8'h01);
        send(8'h6B, 8'h02);
        send(8'h7C, 8'h03);
        cmd_valid = 1'b0;
        t = 0;
        while (rise_cnt < 7 && t < 400) begin tick(); t++; end
        check("mid_rises_at_rst", rise_cnt, 7);
        check("mid_level_at_rst", fifo_level, 3'd2);
        rst = 1'b1;
        cmd_addr = 8'hEE; cmd_data = 8'hEE; cmd_valid = 1'b1;
        tick();
        rst = 1'b0; cmd_valid = 1'b0;
        check("mid_enable", spi_enable, 1'b0);
        check("mid_sclk", spi_clk, 1'b0);
        check("mid_level", fifo_level, 3'd0);
        check("mid_busy", busy, 1'b0);
        check("mid_ready", cmd_ready, 1'b1);
        repeat (400) tick();
        check("mid_no_more_rises", rise_cnt, 7);
        check("mid_no_done", done_cnt, 0);
        check("mid_no_frames", frames.size(), 0);
        check("mid_still_idle", busy, 1'b0);

        // Fast instance: CLK_DIV=1, GAP_CYCLES=1
        f_addr = 8'hC3; f_data = 8'h3C; f_valid = 1'b1;
        tick();
        f_addr = 8'h5A; f_data = 8'h96;
        tick();
        f_valid = 1'b0;
        t = 0;
        while ((f_frames.size() < 2 || f_busy) && t < 300) begin tick(); t++; end
        check("fast_idle", f_busy, 1'b0);
        check("fast_frames", f_frames.size(), 2);
        if (f_frames.size() == 2) begin
            check("fast_word0", f_frames[0], 16'hC33C);
            check("fast_word1", f_frames[1], 16'h5A96);
        end
        check("fast_starts", f_starts.size(), 2);
        if (f_starts.size() == 2) check("fast_spacing", f_starts[1] - f_starts[0], 34);
        check("fast_rises", f_rises, 32);
        check("fast_period_err", f_per_err, 0);
        check("fast_stab_err", f_stab_err, 0);
        check("fast_done_cnt", f_dones, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

endmodule
